// File: rtl/foosball_pkg.sv
// Shared types and defaults for the foosball rod control blocks.
package foosball_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROT6   = 3'd1,
    S_ROT4   = 3'd2,
    S_RETURN = 3'd3,
    S_LOCK   = 3'd4
  } rod_state_t;

  localparam int ROD_MAX_ANGLE      = 4;
  localparam int ROD_LOCKOUT_FRAMES = 30;

  function automatic logic signed [3:0] step_toward_zero(input logic signed [3:0] a);
    logic signed [3:0] r;
    if (a > 4'sd0) begin
      r = a - 4'sd1;
    end else if (a < 4'sd0) begin
      r = a + 4'sd1;
    end else begin
      r = 4'sd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_step_divider.sv
// Counts startOfFrame strobes and emits step_tick once every 'rate' frames.
module frame_step_divider #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic [W-1:0] rate,
  input  logic         clear,
  output logic         step_tick
);

  logic [W-1:0] cnt_r;

  // A clear in the same cycle suppresses the tick so a state change never also steps.
  assign step_tick = startOfFrame && !clear && (cnt_r == (rate - W'(1)));

  // Frame counter: restarts on clear and after every tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_r <= W'(0);
    end else if (clear || step_tick) begin
      cnt_r <= W'(0);
    end else if (startOfFrame) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/rod_rotation_ctrl.sv
// Turns key-hold and over-rotation inputs into a signed rod tilt, a kick pulse
// at full tilt and a lockout flag, stepping on frame strobes.
module rod_rotation_ctrl
  import foosball_pkg::*;
#(
  parameter int MAX_ANGLE              = ROD_MAX_ANGLE,
  parameter int FRAMES_PER_STEP        = 3,
  parameter int RETURN_FRAMES_PER_STEP = 1,
  parameter int LOCKOUT_FRAMES         = ROD_LOCKOUT_FRAMES
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              key6Pressed,
  input  logic              key4Pressed,
  input  logic              max_rotate_6,
  input  logic              max_rotate_4,
  output logic signed [3:0] angle,
  output logic              kick_pulse,
  output logic              kick_dir,
  output logic              locked
);

  localparam int MAX_RATE = (FRAMES_PER_STEP > RETURN_FRAMES_PER_STEP) ?
                            FRAMES_PER_STEP : RETURN_FRAMES_PER_STEP;
  localparam int DIV_W    = $clog2(MAX_RATE) + 1;
  localparam int LOCK_W   = $clog2(LOCKOUT_FRAMES) + 1;

  localparam logic signed [3:0] MAX_POS  = 4'(MAX_ANGLE);
  localparam logic signed [3:0] MAX_NEG  = 4'(-MAX_ANGLE);
  localparam logic signed [3:0] NEAR_POS = 4'(MAX_ANGLE - 1);
  localparam logic signed [3:0] NEAR_NEG = 4'(1 - MAX_ANGLE);
  localparam logic [DIV_W-1:0]  RATE_KEY = DIV_W'(FRAMES_PER_STEP);
  localparam logic [DIV_W-1:0]  RATE_RET = DIV_W'(RETURN_FRAMES_PER_STEP);
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCKOUT_FRAMES);

  rod_state_t        state_r, state_s;
  logic signed [3:0] angle_r, angle_s;
  logic              kick_pulse_r, kick_pulse_s;
  logic              kick_dir_r, kick_dir_s;
  logic              locked_r;
  logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_s;
  logic [DIV_W-1:0]  rate_s;
  logic              div_clear_s;
  logic              step_tick_s;

  assign div_clear_s = (state_s != state_r);

  // Returning and unlocking move at their own rate; key-driven motion at the key rate.
  always_comb begin
    if ((state_r == S_RETURN) || (state_r == S_LOCK)) begin
      rate_s = RATE_RET;
    end else begin
      rate_s = RATE_KEY;
    end
  end

  frame_step_divider #(.W(DIV_W)) u_divider (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .rate         (rate_s),
    .clear        (div_clear_s),
    .step_tick    (step_tick_s)
  );

  // Next-state logic; over-rotation outranks every key, and key6 outranks key4.
  always_comb begin
    state_s = state_r;
    if ((state_r != S_LOCK) && (max_rotate_6 || max_rotate_4)) begin
      state_s = S_LOCK;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (key6Pressed)      state_s = S_ROT6;
          else if (key4Pressed) state_s = S_ROT4;
          else                  state_s = S_IDLE;
        end
        S_ROT6: begin
          if (key6Pressed)      state_s = S_ROT6;
          else if (key4Pressed) state_s = S_ROT4;
          else                  state_s = S_RETURN;
        end
        S_ROT4: begin
          if (key6Pressed)      state_s = S_ROT6;
          else if (key4Pressed) state_s = S_ROT4;
          else                  state_s = S_RETURN;
        end
        S_RETURN: begin
          if (key6Pressed)              state_s = S_ROT6;
          else if (key4Pressed)         state_s = S_ROT4;
          else if (angle_r == 4'sd0)    state_s = S_IDLE;
          else                          state_s = S_RETURN;
        end
        S_LOCK: begin
          if ((angle_r == 4'sd0) && (lock_cnt_r >= LOCK_LIM) &&
              !key6Pressed && !key4Pressed) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_LOCK;
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Angle stepping, kick detection and lockout counting; nothing steps on a transition.
  always_comb begin
    angle_s      = angle_r;
    kick_pulse_s = 1'b0;
    kick_dir_s   = kick_dir_r;
    lock_cnt_s   = lock_cnt_r;
    if (div_clear_s) begin
      if (state_s == S_LOCK) lock_cnt_s = LOCK_W'(0);
      else                   lock_cnt_s = lock_cnt_r;
    end else begin
      case (state_r)
        S_ROT6: begin
          if (step_tick_s && (angle_r < MAX_POS)) begin
            angle_s = angle_r + 4'sd1;
            if (angle_r == NEAR_POS) begin
              kick_pulse_s = 1'b1;
              kick_dir_s   = 1'b1;
            end else begin
              kick_pulse_s = 1'b0;
            end
          end else begin
            angle_s = angle_r;
          end
        end
        S_ROT4: begin
          if (step_tick_s && (angle_r > MAX_NEG)) begin
            angle_s = angle_r - 4'sd1;
            if (angle_r == NEAR_NEG) begin
              kick_pulse_s = 1'b1;
              kick_dir_s   = 1'b0;
            end else begin
              kick_pulse_s = 1'b0;
            end
          end else begin
            angle_s = angle_r;
          end
        end
        S_RETURN: begin
          if (step_tick_s) angle_s = step_toward_zero(angle_r);
          else             angle_s = angle_r;
        end
        S_LOCK: begin
          if (step_tick_s) angle_s = step_toward_zero(angle_r);
          else             angle_s = angle_r;
          // Saturating count so a long key hold cannot wrap the lockout timer.
          if ((angle_r == 4'sd0) && startOfFrame && (lock_cnt_r < LOCK_LIM)) begin
            lock_cnt_s = lock_cnt_r + LOCK_W'(1);
          end else begin
            lock_cnt_s = lock_cnt_r;
          end
        end
        default: angle_s = angle_r;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= S_IDLE;
      angle_r      <= 4'sd0;
      kick_pulse_r <= 1'b0;
      kick_dir_r   <= 1'b0;
      locked_r     <= 1'b0;
      lock_cnt_r   <= LOCK_W'(0);
    end else begin
      state_r      <= state_s;
      angle_r      <= angle_s;
      kick_pulse_r <= kick_pulse_s;
      kick_dir_r   <= kick_dir_s;
      locked_r     <= (state_s == S_LOCK);
      lock_cnt_r   <= lock_cnt_s;
    end
  end

  assign angle      = angle_r;
  assign kick_pulse = kick_pulse_r;
  assign kick_dir   = kick_dir_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_rod_rotation_ctrl.sv
// Directed scoreboard bench for rod_rotation_ctrl with default parameters.
module tb_rod_rotation_ctrl;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic              key6Pressed;
  logic              key4Pressed;
  logic              max_rotate_6;
  logic              max_rotate_4;
  logic signed [3:0] angle;
  logic              kick_pulse;
  logic              kick_dir;
  logic              locked;

  localparam int K_ANGLE = 0;
  localparam int K_LOCK  = 1;
  localparam int K_KICKS = 2;
  localparam int K_DIR   = 3;
  localparam int K_PULSE = 4;

  typedef struct {
    string tag;
    int    kind;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   kicks = 0;

  always #5 clk = ~clk;

  rod_rotation_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .key6Pressed  (key6Pressed),
    .key4Pressed  (key4Pressed),
    .max_rotate_6 (max_rotate_6),
    .max_rotate_4 (max_rotate_4),
    .angle        (angle),
    .kick_pulse   (kick_pulse),
    .kick_dir     (kick_dir),
    .locked       (locked)
  );

  function automatic int observe(input int kind);
    case (kind)
      K_ANGLE: return int'(angle);
      K_LOCK:  return int'(locked);
      K_KICKS: return kicks;
      K_DIR:   return int'(kick_dir);
      K_PULSE: return int'(kick_pulse);
      default: return -99;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input int val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = val;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    int   obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      tests_run++;
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame = strobe cycle plus two quiet cycles; kick pulses are tallied in each.
  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      kicks += int'(kick_pulse);
      @(negedge clk);
      kicks += int'(kick_pulse);
      @(negedge clk);
      kicks += int'(kick_pulse);
    end
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    key6Pressed  = 1'b0;
    key4Pressed  = 1'b0;
    max_rotate_6 = 1'b0;
    max_rotate_4 = 1'b0;
    cyc(3);
    expect_val("reset_angle", K_ANGLE, 0);
    expect_val("reset_locked", K_LOCK, 0);
    expect_val("reset_kick_dir", K_DIR, 0);
    expect_val("reset_kick_pulse", K_PULSE, 0);
    check();
    resetN = 1'b1;
    cyc(2);

    // Reset mid-operation
    key6Pressed = 1'b1;
    cyc(1);
    frames(6);
    expect_val("pre_reset_angle", K_ANGLE, 2);
    check();
    #2;
    resetN = 1'b0;
    #1;
    expect_val("async_reset_angle", K_ANGLE, 0);
    expect_val("async_reset_locked", K_LOCK, 0);
    check();
    key6Pressed = 1'b0;
    cyc(2);
    resetN = 1'b1;
    cyc(2);

    // Forward full tilt
    key6Pressed = 1'b1;
    cyc(1);
    kicks = 0;
    frames(2);
    expect_val("fwd_before_first_step", K_ANGLE, 0);
    check();
    frames(1);
    expect_val("fwd_frame3", K_ANGLE, 1);
    check();
    frames(3);
    expect_val("fwd_frame6", K_ANGLE, 2);
    check();
    frames(3);
    expect_val("fwd_frame9", K_ANGLE, 3);
    expect_val("fwd_no_early_kick", K_KICKS, 0);
    check();
    frames(3);
    expect_val("fwd_frame12", K_ANGLE, 4);
    expect_val("fwd_kick_count", K_KICKS, 1);
    expect_val("fwd_kick_dir", K_DIR, 1);
    check();
    frames(3);
    expect_val("fwd_saturated", K_ANGLE, 4);
    expect_val("fwd_no_repeat_kick", K_KICKS, 1);
    check();

    // Release and return to zero
    key6Pressed = 1'b0;
    cyc(1);
    frames(1);
    expect_val("ret_step1", K_ANGLE, 3);
    check();
    frames(2);
    expect_val("ret_step3", K_ANGLE, 1);
    check();
    frames(1);
    expect_val("ret_zero", K_ANGLE, 0);
    expect_val("ret_unlocked", K_LOCK, 0);
    check();
    cyc(2);

    // Reversal from +2 down to -4
    key6Pressed = 1'b1;
    cyc(1);
    frames(6);
    expect_val("rev_start", K_ANGLE, 2);
    check();
    key6Pressed = 1'b0;
    key4Pressed = 1'b1;
    cyc(1);
    kicks = 0;
    frames(3);
    expect_val("rev_step1", K_ANGLE, 1);
    check();
    frames(6);
    expect_val("rev_neg1", K_ANGLE, -1);
    expect_val("rev_no_early_kick", K_KICKS, 0);
    check();
    frames(9);
    expect_val("rev_neg4", K_ANGLE, -4);
    expect_val("rev_kick_count", K_KICKS, 1);
    expect_val("rev_kick_dir", K_DIR, 0);
    check();
    frames(3);
    expect_val("rev_saturated", K_ANGLE, -4);
    check();
    key4Pressed = 1'b0;
    cyc(1);
    frames(4);
    expect_val("rev_return_zero", K_ANGLE, 0);
    check();
    cyc(2);

    // Both keys from idle: key6 wins
    key6Pressed = 1'b1;
    key4Pressed = 1'b1;
    cyc(1);
    frames(3);
    expect_val("both_keys_forward", K_ANGLE, 1);
    check();
    key6Pressed = 1'b0;
    key4Pressed = 1'b0;
    cyc(1);
    frames(1);
    expect_val("both_keys_return", K_ANGLE, 0);
    check();
    cyc(2);

    // Over-rotation lockout with key still held
    key6Pressed = 1'b1;
    cyc(1);
    frames(12);
    expect_val("lock_pre_angle", K_ANGLE, 4);
    check();
    max_rotate_6 = 1'b1;
    cyc(1);
    expect_val("lock_entered", K_LOCK, 1);
    expect_val("lock_no_step_on_entry", K_ANGLE, 4);
    check();
    kicks = 0;
    frames(4);
    expect_val("lock_angle_zero", K_ANGLE, 0);
    check();
    frames(30);
    expect_val("lock_held_key", K_LOCK, 1);
    expect_val("lock_held_angle", K_ANGLE, 0);
    expect_val("lock_no_kick", K_KICKS, 0);
    check();
    key6Pressed  = 1'b0;
    max_rotate_6 = 1'b0;
    cyc(1);
    expect_val("lock_release_exit", K_LOCK, 0);
    check();
    cyc(2);

    // Lockout duration boundary via max_rotate_4 with no keys
    max_rotate_4 = 1'b1;
    cyc(1);
    max_rotate_4 = 1'b0;
    expect_val("lock4_entered", K_LOCK, 1);
    check();
    frames(29);
    expect_val("lock4_frame29", K_LOCK, 1);
    check();
    frames(1);
    expect_val("lock4_frame30_exit", K_LOCK, 0);
    check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
